vga_pattern_gen_module: RTL and testbench

Parametrised VGA test-pattern generator and successor to the fixed four-region colour controller. It sits between the VGA sync/address generator and the RGB DAC pins. From the pixel address it produces registered RGB565-style colour for one of four runtime-selectable patterns: colour bars, grey ramp, checkerboard, and a bouncing box animated once per frame. Mode changes are deferred to the frame boundary so no frame is torn.

---
 rtl/vga_pattern_gen_module.sv | 214 +++++++++++++++++++++
 tb/tb_vga_pattern_gen_module.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen_module.sv
// VGA test-pattern generator: colour bars, grey ramp, checkerboard and a bouncing box, with frame-aligned mode switching.
// Optional full-white one-pixel border when VGA_PATGEN_BORDER_EN is defined.
module vga_pattern_gen_module #(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 600,
  parameter int R_W        = 5,
  parameter int G_W        = 6,
  parameter int B_W        = 5,
  parameter int BAR_COUNT  = 8,
  parameter int GRAD_SHIFT = 2,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 64
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           Ready_Sig,
  input  logic [10:0]    Column_Addr_Sig,
  input  logic [9:0]     Row_Addr_Sig,
  input  logic [1:0]     Mode_Sel,
  input  logic           Mode_Load,
  output logic [R_W-1:0] Red_Sig,
  output logic [G_W-1:0] Green_Sig,
  output logic [B_W-1:0] Blue_Sig,
  output logic           Valid_Sig,
  output logic           Frame_Tick,
  output logic [1:0]     Mode_Cur
);

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BOX   = 2'd3
  } mode_t;

  localparam logic [11:0] H_ACT_W  = 12'(H_ACTIVE);
  localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
  localparam logic [10:0] H_LAST   = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [10:0] BAR_W    = 11'(H_ACTIVE / BAR_COUNT);
  localparam logic [10:0] BAR_MAX  = 11'(BAR_COUNT - 1);
  localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  Y_MAX    = 10'(V_ACTIVE - BOX_SIZE);
  localparam logic [11:0] BOX_X_SZ = 12'(BOX_SIZE);
  localparam logic [10:0] BOX_Y_SZ = 11'(BOX_SIZE);

  mode_t           r_mode_pend;
  mode_t           r_mode_act;
  logic [10:0]     r_box_x;
  logic [9:0]      r_box_y;
  logic            r_dir_x;
  logic            r_dir_y;
  logic [R_W-1:0]  r_red;
  logic [G_W-1:0]  r_green;
  logic [B_W-1:0]  r_blue;
  logic            r_valid;
  logic            r_tick;

  logic            w_in_range;
  logic            w_fe;
  logic [10:0]     w_bar_q;
  logic [2:0]      w_bar_k;
  logic [R_W-1:0]  w_ramp_r;
  logic [G_W-1:0]  w_ramp_g;
  logic [B_W-1:0]  w_ramp_b;
  logic            w_check;
  logic [11:0]     w_box_x_end;
  logic [10:0]     w_box_y_end;
  logic            w_in_box;
  logic            w_border;
  logic [R_W-1:0]  w_pix_r;
  logic [G_W-1:0]  w_pix_g;
  logic [B_W-1:0]  w_pix_b;

  assign w_in_range = Ready_Sig
                   && ({1'b0, Column_Addr_Sig} < H_ACT_W)
                   && ({1'b0, Row_Addr_Sig} < V_ACT_W);
  assign w_fe = w_in_range && (Column_Addr_Sig == H_LAST) && (Row_Addr_Sig == V_LAST);

  // Bars past the last full-width bar clamp to the final bar index.
  assign w_bar_q = Column_Addr_Sig / BAR_W;
  assign w_bar_k = (w_bar_q > BAR_MAX) ? 3'(BAR_MAX) : 3'(w_bar_q);

  assign w_ramp_r = R_W'(Column_Addr_Sig >> GRAD_SHIFT);
  assign w_ramp_b = B_W'(Column_Addr_Sig >> GRAD_SHIFT);
  assign w_ramp_g = G_W'(Column_Addr_Sig >> (GRAD_SHIFT - 1));

  assign w_check = Column_Addr_Sig[CHECK_LOG2] ^ Row_Addr_Sig[CHECK_LOG2];

  // Box extents carry one extra bit so the far edge never wraps.
  assign w_box_x_end = {1'b0, r_box_x} + BOX_X_SZ;
  assign w_box_y_end = {1'b0, r_box_y} + BOX_Y_SZ;
  assign w_in_box = (Column_Addr_Sig >= r_box_x)
                 && ({1'b0, Column_Addr_Sig} < w_box_x_end)
                 && (Row_Addr_Sig >= r_box_y)
                 && ({1'b0, Row_Addr_Sig} < w_box_y_end);

`ifdef VGA_PATGEN_BORDER_EN
  assign w_border = (Column_Addr_Sig == 11'd0) || (Column_Addr_Sig == H_LAST)
                 || (Row_Addr_Sig == 10'd0) || (Row_Addr_Sig == V_LAST);
`else
  assign w_border = 1'b0;
`endif

  always_comb begin
    w_pix_r = '0;
    w_pix_g = '0;
    w_pix_b = '0;
    if (w_in_range) begin
      case (r_mode_act)
        MODE_BARS: begin
          w_pix_r = {R_W{~w_bar_k[1]}};
          w_pix_g = {G_W{~w_bar_k[2]}};
          w_pix_b = {B_W{~w_bar_k[0]}};
        end
        MODE_RAMP: begin
          w_pix_r = w_ramp_r;
          w_pix_g = w_ramp_g;
          w_pix_b = w_ramp_b;
        end
        MODE_CHECK: begin
          w_pix_r = {R_W{w_check}};
          w_pix_g = {G_W{w_check}};
          w_pix_b = {B_W{w_check}};
        end
        default: begin
          w_pix_r = {R_W{w_in_box}};
          w_pix_g = {G_W{w_in_box}};
          w_pix_b = '1;
        end
      endcase
      if (w_border) begin
        w_pix_r = '1;
        w_pix_g = '1;
        w_pix_b = '1;
      end
    end
  end

  // A load coinciding with frame end bypasses the pending register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mode_pend <= MODE_BARS;
      r_mode_act  <= MODE_BARS;
    end else begin
      if (Mode_Load)
        r_mode_pend <= mode_t'(Mode_Sel);
      if (w_fe)
        r_mode_act <= Mode_Load ? mode_t'(Mode_Sel) : r_mode_pend;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_box_x <= '0;
      r_dir_x <= 1'b1;
    end else if (w_fe) begin
      if (r_dir_x && (r_box_x == X_MAX)) begin
        r_dir_x <= 1'b0;
        r_box_x <= r_box_x - 11'd1;
      end else if (!r_dir_x && (r_box_x == 11'd0)) begin
        r_dir_x <= 1'b1;
        r_box_x <= 11'd1;
      end else if (r_dir_x) begin
        r_box_x <= r_box_x + 11'd1;
      end else begin
        r_box_x <= r_box_x - 11'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_box_y <= '0;
      r_dir_y <= 1'b1;
    end else if (w_fe) begin
      if (r_dir_y && (r_box_y == Y_MAX)) begin
        r_dir_y <= 1'b0;
        r_box_y <= r_box_y - 10'd1;
      end else if (!r_dir_y && (r_box_y == 10'd0)) begin
        r_dir_y <= 1'b1;
        r_box_y <= 10'd1;
      end else if (r_dir_y) begin
        r_box_y <= r_box_y + 10'd1;
      end else begin
        r_box_y <= r_box_y - 10'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
      r_valid <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_red   <= w_pix_r;
      r_green <= w_pix_g;
      r_blue  <= w_pix_b;
      r_valid <= w_in_range;
      r_tick  <= w_fe;
    end
  end

  assign Red_Sig    = r_red;
  assign Green_Sig  = r_green;
  assign Blue_Sig   = r_blue;
  assign Valid_Sig  = r_valid;
  assign Frame_Tick = r_tick;
  assign Mode_Cur   = r_mode_act;

endmodule

// File: tb/tb_vga_pattern_gen_module.sv
// Self-checking bench for vga_pattern_gen_module against a frame-level reference model.
module tb_vga_pattern_gen_module;

  localparam int H   = 800;
  localparam int V   = 600;
  localparam int BOX = 64;
  localparam int XM  = H - BOX;
  localparam int YM  = V - BOX;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Ready_Sig;
  logic [10:0] Column_Addr_Sig;
  logic [9:0]  Row_Addr_Sig;
  logic [1:0]  Mode_Sel;
  logic        Mode_Load;
  logic [4:0]  Red_Sig;
  logic [5:0]  Green_Sig;
  logic [4:0]  Blue_Sig;
  logic        Valid_Sig;
  logic        Frame_Tick;
  logic [1:0]  Mode_Cur;

  int errors = 0;
  int checks = 0;
  int m_pend = 0;
  int m_act  = 0;
  int fe_cnt = 0;

  vga_pattern_gen_module dut (
    .CLK(CLK), .RST(RST), .Ready_Sig(Ready_Sig),
    .Column_Addr_Sig(Column_Addr_Sig), .Row_Addr_Sig(Row_Addr_Sig),
    .Mode_Sel(Mode_Sel), .Mode_Load(Mode_Load),
    .Red_Sig(Red_Sig), .Green_Sig(Green_Sig), .Blue_Sig(Blue_Sig),
    .Valid_Sig(Valid_Sig), .Frame_Tick(Frame_Tick), .Mode_Cur(Mode_Cur)
  );

  always #5 CLK = ~CLK;

  // Box position after n frame ends is a triangle wave of period 2*max.
  function automatic int tri_pos(int n, int m);
    int p;
    p = n % (2 * m);
    return (p <= m) ? p : 2 * m - p;
  endfunction

  function automatic logic [15:0] exp_pix(bit inr, int col, int row, int mode, int bx, int by);
    int r, g, b, k;
    r = 0; g = 0; b = 0;
    if (inr) begin
      case (mode)
        0: begin
          k = col / (H / 8);
          if (k > 7) k = 7;
          r = (k & 2) ? 0 : 31;
          g = (k & 4) ? 0 : 63;
          b = (k & 1) ? 0 : 31;
        end
        1: begin
          r = (col / 4) % 32;
          b = (col / 4) % 32;
          g = (col / 2) % 64;
        end
        2: begin
          if (((col / 32) + (row / 32)) % 2 == 1) begin r = 31; g = 63; b = 31; end
        end
        default: begin
          b = 31;
          if (col >= bx && col < bx + BOX && row >= by && row < by + BOX) begin r = 31; g = 63; end
        end
      endcase
`ifdef VGA_PATGEN_BORDER_EN
      if (col == 0 || col == H - 1 || row == 0 || row == V - 1) begin r = 31; g = 63; b = 31; end
`endif
    end
    return {r[4:0], g[5:0], b[4:0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rdy, input int col, input int row, input bit ld,
                      input logic [1:0] sel, input string tag);
    bit inr, fe;
    logic [15:0] e;
    Ready_Sig = rdy;
    Column_Addr_Sig = 11'(col);
    Row_Addr_Sig = 10'(row);
    Mode_Load = ld;
    Mode_Sel = sel;
    inr = rdy && col < H && row < V;
    fe = inr && col == H - 1 && row == V - 1;
    e = exp_pix(inr, col, row, m_act, tri_pos(fe_cnt, XM), tri_pos(fe_cnt, YM));
    @(posedge CLK);
    #1;
    if (fe) begin
      m_act = ld ? int'(sel) : m_pend;
      fe_cnt++;
    end
    if (ld) m_pend = int'(sel);
    check({tag, ".r"}, 16'(Red_Sig), 16'(e[15:11]));
    check({tag, ".g"}, 16'(Green_Sig), 16'(e[10:5]));
    check({tag, ".b"}, 16'(Blue_Sig), 16'(e[4:0]));
    check({tag, ".valid"}, 16'(Valid_Sig), 16'(inr));
    check({tag, ".tick"}, 16'(Frame_Tick), 16'(fe));
    check({tag, ".mode"}, 16'(Mode_Cur), 16'(m_act));
    Mode_Load = 1'b0;
  endtask

  task automatic probe_box(input string tag);
    int bx, by;
    bx = tri_pos(fe_cnt, XM);
    by = tri_pos(fe_cnt, YM);
    step(1, bx, by, 0, 0, {tag, ".in0"});
    step(1, bx + BOX - 1, by + BOX - 1, 0, 0, {tag, ".in1"});
    if (bx > 0) step(1, bx - 1, by + 1, 0, 0, {tag, ".left"});
    if (bx + BOX < H) step(1, bx + BOX, by + 1, 0, 0, {tag, ".right"});
    if (by > 0) step(1, bx + 1, by - 1, 0, 0, {tag, ".above"});
    if (by + BOX < V) step(1, bx + 1, by + BOX, 0, 0, {tag, ".below"});
  endtask

  initial begin
    RST = 1'b1;
    Ready_Sig = 1'b0;
    Column_Addr_Sig = '0;
    Row_Addr_Sig = '0;
    Mode_Sel = '0;
    Mode_Load = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst.r", 16'(Red_Sig), 16'd0);
    check("rst.g", 16'(Green_Sig), 16'd0);
    check("rst.b", 16'(Blue_Sig), 16'd0);
    check("rst.valid", 16'(Valid_Sig), 16'd0);
    check("rst.tick", 16'(Frame_Tick), 16'd0);
    check("rst.mode", 16'(Mode_Cur), 16'd0);
    RST = 1'b0;

    // Bars along row 0
    step(1, 0, 0, 0, 0, "bars_c0");
    check("bars_c0.white", {Red_Sig, Green_Sig, Blue_Sig}, 16'hFFFF);
    step(1, 100, 0, 0, 0, "bars_c100");
    check("bars_c100.yellow", {Red_Sig, Green_Sig, Blue_Sig}, {5'h1F, 6'h3F, 5'h00});
    step(1, 700, 0, 0, 0, "bars_c700");
    for (int c = 0; c < H; c += 37) step(1, c, 0, 0, 0, "bars_sweep");
    step(1, 799, 5, 0, 0, "bars_last");

    // Out-of-range and not-ready pixels
    step(0, 10, 10, 0, 0, "notready");
    step(1, 800, 0, 0, 0, "col800");
    step(1, 10, 600, 0, 0, "row600");
    step(0, 799, 599, 0, 0, "fe_notready");
    step(1, 800, 599, 0, 0, "fe_col800");

    // Deferred mode change to checker
    step(1, 50, 50, 1, 2, "load_chk");
    step(1, 32, 0, 0, 0, "still_bars");
    check("still_bars.mode0", 16'(Mode_Cur), 16'd0);
    step(1, 799, 599, 0, 0, "fe_chk");
    check("fe_chk.mode2", 16'(Mode_Cur), 16'd2);
    step(1, 32, 0, 0, 0, "chk_32_0");
    step(1, 32, 32, 0, 0, "chk_32_32");
`ifndef VGA_PATGEN_BORDER_EN
    check("chk_32_32.black", {Red_Sig, Green_Sig, Blue_Sig}, 16'h0000);
`endif
    step(1, 0, 40, 0, 0, "chk_0_40");
    step(1, 799, 40, 0, 0, "chk_799_40");
    step(1, 40, 599, 0, 0, "chk_40_599");
    step(1, 40, 40, 0, 0, "chk_40_40");

    // Load coincident with frame end goes straight to active
    step(1, 799, 599, 1, 1, "fe_load_ramp");
    check("fe_load_ramp.mode1", 16'(Mode_Cur), 16'd1);
    step(1, 8, 0, 0, 0, "ramp_8_0");
`ifndef VGA_PATGEN_BORDER_EN
    check("ramp_8_0.rgb", {Red_Sig, Green_Sig, Blue_Sig}, {5'd2, 6'd4, 5'd2});
`endif
    for (int c = 3; c < H; c += 53) step(1, c, 7, 0, 0, "ramp_sweep");

    // Box animation through both turnarounds
    step(1, 799, 599, 1, 3, "fe_load_box");
    probe_box("box_start");
    while (fe_cnt < YM) step(1, 799, 599, 0, 0, "box_fe");
    probe_box("box_y536");
    step(1, 799, 599, 0, 0, "box_fe");
    probe_box("box_y535");
    while (fe_cnt < XM) step(1, 799, 599, 0, 0, "box_fe");
    probe_box("box_x736");
    step(1, 799, 599, 0, 0, "box_fe");
    probe_box("box_x735");

    // Asynchronous reset mid-frame discards pending mode and box state
    step(1, 20, 20, 1, 2, "pend_before_rst");
    #2;
    RST = 1'b1;
    #1;
    check("arst.r", 16'(Red_Sig), 16'd0);
    check("arst.g", 16'(Green_Sig), 16'd0);
    check("arst.b", 16'(Blue_Sig), 16'd0);
    check("arst.valid", 16'(Valid_Sig), 16'd0);
    check("arst.mode", 16'(Mode_Cur), 16'd0);
    m_pend = 0;
    m_act = 0;
    fe_cnt = 0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    step(1, 799, 599, 0, 0, "post_rst_fe");
    step(1, 0, 1, 0, 0, "post_rst_bars");
    step(1, 799, 599, 1, 3, "post_rst_box");
    probe_box("box_after_rst");
    step(1, 0, 0, 0, 0, "box_00_blue");

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      bit rdy, ld;
      int col, row;
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) begin
        col = H - 1;
        row = V - 1;
      end else begin
        col = $urandom_range(0, 840);
        row = $urandom_range(0, 630);
      end
      ld = ($urandom_range(0, 15) == 0);
      step(rdy, col, row, ld, 2'($urandom_range(0, 3)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
